// File: rtl/oen_fill_pkg.sv
// Shared constants for the output-enable fill buffer: default geometry, FSM state codes and
// the overflow counter width used when OEN_FILL_OVF_CNT_EN is defined.
package oen_fill_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 16;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned OvfCntW  = 16;

    // FSM state codes
    localparam logic [1:0] StFill    = 2'd0;
    localparam logic [1:0] StFull    = 2'd1;
    localparam logic [1:0] StWaitClr = 2'd2;

endpackage

// File: rtl/oen_fill_ram.sv
// DEPTH x DATA_W simple dual-port store: synchronous write, registered read.
// The read register is reset so the readout bus is zero until the first read.
module oen_fill_ram
    import oen_fill_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              OEN_CLR_Clk,
    input  logic              OEN_CLR_Rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array write port
    always_ff @(posedge OEN_CLR_Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last word between reads
    always_ff @(posedge OEN_CLR_Clk or posedge OEN_CLR_Rst) begin
        if (OEN_CLR_Rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/oen_out_fill.sv
// Write side of the output-enable handshake. Buffers one frame of result words, flags it full,
// drains it to the host only while the output-enable clear is low, then waits for the
// repeat-clear acknowledge before rearming.
// Optional build macro: OEN_FILL_OVF_CNT_EN adds a saturating dropped-write counter port.
module oen_out_fill
    import oen_fill_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              OEN_CLR_Clk,
    input  logic              OEN_CLR_Rst,
    input  logic              OEN_FILL_Wr_Valid,
    input  logic [DATA_W-1:0] OEN_FILL_Wr_Data,
    output logic              OEN_FILL_Wr_Ready,
    input  logic              OEN_FILL_Rd_En,
    output logic [DATA_W-1:0] OEN_FILL_Rd_Data,
    output logic              OEN_FILL_Rd_Valid,
    input  logic              OEN_FILL_Clr,
    input  logic              OEN_FILL_Rptclr,
    output logic              OEN_FILL_Flag_Out_Full,
    output logic [ADDR_W:0]   OEN_FILL_Count
`ifdef OEN_FILL_OVF_CNT_EN
    ,
    output logic [OvfCntW-1:0] OEN_FILL_Ovf_Cnt
`endif
);

    localparam logic [ADDR_W:0]   FullCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_ready_q;
    logic              flag_q;
    logic              rd_valid_q;
    logic              ram_we;
    logic              ram_re;

    // Next-state: writes only in fill, reads only in full, rearm on repeat-clear
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        case (state_q)
            StFill: begin
                if (OEN_FILL_Wr_Valid && wr_ready_q) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    count_d  = count_q + CntOne;
                    if (count_q == FullCnt - CntOne) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                // Reads while clear is high are dropped, not queued
                if (OEN_FILL_Rd_En && !OEN_FILL_Clr && (count_q != '0)) begin
                    ram_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + PtrOne;
                    count_d  = count_q - CntOne;
                    if (count_q == CntOne) begin
                        state_d = StWaitClr;
                    end
                end
            end
            StWaitClr: begin
                if (OEN_FILL_Rptclr) begin
                    state_d  = StFill;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // State, pointers, count and registered status outputs
    always_ff @(posedge OEN_CLR_Clk or posedge OEN_CLR_Rst) begin
        if (OEN_CLR_Rst) begin
            state_q    <= StFill;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
            flag_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Ready and flag are registered from the next state so they track it exactly
            wr_ready_q <= (state_d == StFill);
            flag_q     <= (state_d == StFull);
            rd_valid_q <= ram_re;
        end
    end

    oen_fill_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .OEN_CLR_Clk (OEN_CLR_Clk),
        .OEN_CLR_Rst (OEN_CLR_Rst),
        .wr_en       (ram_we),
        .wr_addr     (wr_ptr_q),
        .wr_data     (OEN_FILL_Wr_Data),
        .rd_en       (ram_re),
        .rd_addr     (rd_ptr_q),
        .rd_data     (OEN_FILL_Rd_Data)
    );

    assign OEN_FILL_Wr_Ready      = wr_ready_q;
    assign OEN_FILL_Rd_Valid      = rd_valid_q;
    assign OEN_FILL_Flag_Out_Full = flag_q;
    assign OEN_FILL_Count         = count_q;

`ifdef OEN_FILL_OVF_CNT_EN
    logic [OvfCntW-1:0] ovf_cnt_q;

    // Saturating count of write attempts offered while not ready; only reset clears it
    always_ff @(posedge OEN_CLR_Clk or posedge OEN_CLR_Rst) begin
        if (OEN_CLR_Rst) begin
            ovf_cnt_q <= '0;
        end else if (OEN_FILL_Wr_Valid && !wr_ready_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OvfCntW'(1);
        end
    end

    assign OEN_FILL_Ovf_Cnt = ovf_cnt_q;
`else
    // Dropped writes are silent in this build
`endif

endmodule

// File: tb/tb_oen_out_fill.sv
// Self-checking bench for oen_out_fill against a queue-based frame model.
// Define OEN_FILL_OVF_CNT_EN to also exercise the dropped-write counter.
module tb_oen_out_fill;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       clr;
    logic       rptclr;
    logic       flag;
    logic [4:0] count;
`ifdef OEN_FILL_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: frame contents as a FIFO queue plus the frame phase
    logic [7:0] m_q[$];
    int         m_phase;   // 0 filling, 1 full/draining, 2 waiting for repeat-clear
    bit         m_ready;
    bit         m_flag;
    bit         m_rvalid;
    logic [7:0] m_rdata;
    int         m_ovf;

    oen_out_fill dut (
        .OEN_CLR_Clk            (clk),
        .OEN_CLR_Rst            (rst),
        .OEN_FILL_Wr_Valid      (wr_valid),
        .OEN_FILL_Wr_Data       (wr_data),
        .OEN_FILL_Wr_Ready      (wr_ready),
        .OEN_FILL_Rd_En         (rd_en),
        .OEN_FILL_Rd_Data       (rd_data),
        .OEN_FILL_Rd_Valid      (rd_valid),
        .OEN_FILL_Clr           (clr),
        .OEN_FILL_Rptclr        (rptclr),
        .OEN_FILL_Flag_Out_Full (flag),
        .OEN_FILL_Count         (count)
`ifdef OEN_FILL_OVF_CNT_EN
        ,
        .OEN_FILL_Ovf_Cnt       (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_phase  = 0;
        m_ready  = 1'b0;
        m_flag   = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 8'h00;
        m_ovf    = 0;
    endtask

    // Apply the frame rules for the coming edge, then advance to 1 time unit after it
    task automatic step();
        if (wr_valid && !m_ready && m_ovf < 65535) m_ovf++;
        m_rvalid = 1'b0;
        case (m_phase)
            0: if (wr_valid && m_ready) begin
                m_q.push_back(wr_data);
                if (m_q.size() == 16) m_phase = 1;
            end
            1: if (rd_en && !clr && m_q.size() != 0) begin
                m_rdata  = m_q.pop_front();
                m_rvalid = 1'b1;
                if (m_q.size() == 0) m_phase = 2;
            end
            default: if (rptclr) m_phase = 0;
        endcase
        m_ready = (m_phase == 0);
        m_flag  = (m_phase == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wr_valid = 0; wr_data = 0; rd_en = 0; clr = 1; rptclr = 0;
        rst = 0;
        #2 rst = 1;
        #1;
        model_reset();
        checks++; if (count !== 5'd0) begin errors++;
            $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (flag !== 1'b0) begin errors++;
            $display("FAIL reset_flag got %b want 0", flag); end
        checks++; if (wr_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b want 0", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++;
            $display("FAIL reset_rdata got %h want 00", rd_data); end
        @(negedge clk) rst = 0;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++;
            $display("FAIL ready_after_reset got %b want 1", wr_ready); end
    endtask

    task automatic test_fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1; wr_data = base + 8'(i);
            step();
            checks++; if (count !== 5'(m_q.size())) begin errors++;
                $display("FAIL fill_count[%0d] got %0d want %0d", i, count, m_q.size()); end
        end
        wr_valid = 0;
        checks++; if (flag !== 1'b1) begin errors++;
            $display("FAIL fill_flag got %b want 1", flag); end
        checks++; if (count !== 5'd16) begin errors++;
            $display("FAIL fill_count_full got %0d want 16", count); end
        checks++; if (wr_ready !== 1'b0) begin errors++;
            $display("FAIL fill_ready got %b want 0", wr_ready); end
    endtask

`ifdef OEN_FILL_OVF_CNT_EN
    task automatic test_ovf();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 8'hEE;
            step();
        end
        wr_valid = 0;
        checks++; if (ovf_cnt !== 16'(m_ovf) || m_ovf != 4) begin errors++;
            $display("FAIL ovf_cnt got %0d want 4", ovf_cnt); end
        checks++; if (count !== 5'd16) begin errors++;
            $display("FAIL ovf_count got %0d want 16", count); end
    endtask
`endif

    task automatic test_clr_block();
        clr = 1; rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd_valid !== 1'b0) begin errors++;
                $display("FAIL clr_block_rvalid[%0d] got %b want 0", i, rd_valid); end
            checks++; if (count !== 5'd16) begin errors++;
                $display("FAIL clr_block_count[%0d] got %0d want 16", i, count); end
        end
        rd_en = 0;
    endtask

    task automatic test_drain(input logic [7:0] base);
        clr = 0; rd_en = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (rd_valid !== 1'b1) begin errors++;
                $display("FAIL drain_rvalid[%0d] got %b want 1", i, rd_valid); end
            checks++; if (rd_data !== m_rdata || m_rdata !== base + 8'(i)) begin errors++;
                $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, base + 8'(i)); end
            checks++; if (flag !== m_flag) begin errors++;
                $display("FAIL drain_flag[%0d] got %b want %b", i, flag, m_flag); end
        end
        rd_en = 0; clr = 1;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL drain_pulse got %b want 0", rd_valid); end
        checks++; if (flag !== 1'b0 || count !== 5'd0) begin errors++;
            $display("FAIL drain_end flag %b count %0d want 0 0", flag, count); end
    endtask

    task automatic test_wait_clr();
        rptclr = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (wr_ready !== 1'b0 || count !== 5'd0) begin errors++;
                $display("FAIL wait_hold[%0d] ready %b count %0d want 0 0", i, wr_ready, count); end
        end
        rptclr = 1;
        step();
        rptclr = 0;
        checks++; if (wr_ready !== 1'b1) begin errors++;
            $display("FAIL wait_exit_ready got %b want 1", wr_ready); end
        checks++; if (count !== 5'd0) begin errors++;
            $display("FAIL wait_exit_count got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1; wr_data = 8'($urandom);
            step();
        end
        wr_valid = 0;
        checks++; if (count !== 5'd7) begin errors++;
            $display("FAIL mid_count_pre got %0d want 7", count); end
        #2 rst = 1;
        #1;
        model_reset();
        checks++; if (count !== 5'd0 || flag !== 1'b0) begin errors++;
            $display("FAIL mid_reset count %0d flag %b want 0 0", count, flag); end
        @(negedge clk) rst = 0;
        step();
        test_fill(8'hA0);
        test_drain(8'hA0);
        rptclr = 1;
        step();
        rptclr = 0;
    endtask

    task automatic test_random();
        int frames = 0;
        int cyc = 0;
        while (frames < 3 && cyc < 3000) begin
            int prev_phase;
            wr_valid = ($urandom_range(3) != 0);
            wr_data  = 8'($urandom);
            rd_en    = $urandom_range(1);
            clr      = ($urandom_range(9) < 3);
            rptclr   = ($urandom_range(3) == 0);
            prev_phase = m_phase;
            step();
            cyc++;
            if (prev_phase == 2 && m_phase == 0) frames++;
            checks++; if (count !== 5'(m_q.size()) || flag !== m_flag || wr_ready !== m_ready)
                begin errors++;
                $display("FAIL rand_status[%0d] count %0d flag %b ready %b want %0d %b %b",
                         cyc, count, flag, wr_ready, m_q.size(), m_flag, m_ready); end
            checks++; if (rd_valid !== m_rvalid || rd_data !== m_rdata) begin errors++;
                $display("FAIL rand_read[%0d] valid %b data %h want %b %h",
                         cyc, rd_valid, rd_data, m_rvalid, m_rdata); end
`ifdef OEN_FILL_OVF_CNT_EN
            checks++; if (ovf_cnt !== 16'(m_ovf)) begin errors++;
                $display("FAIL rand_ovf[%0d] got %0d want %0d", cyc, ovf_cnt, m_ovf); end
`endif
        end
        wr_valid = 0; rd_en = 0; rptclr = 0; clr = 1;
        checks++; if (frames < 3) begin errors++;
            $display("FAIL rand_timeout frames %0d want 3", frames); end
    endtask

    initial begin
        test_reset();
        test_fill(8'h00);
`ifdef OEN_FILL_OVF_CNT_EN
        test_ovf();
`endif
        test_clr_block();
        test_drain(8'h00);
        test_wait_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
